// File: rtl/fw_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// fw_cmd_dispatch
//
// Purpose:
//   Decodes the firmware command word {device_id[31:28], op_code[27:24],
//   body[23:0]}. It holds the static-config and execute-config registers,
//   forwards array/data op codes to downstream engines and launches one of
//   NUM_TESTS test engines. A 32-bit status word records command activity,
//   test completion, watchdog timeout and execute errors.
//
// Ports:
//   fw_axi_clk, fw_rst   clock, asynchronous active-high reset
//   cmd_wdata/valid      command word and strobe
//   cmd_ready            always 1; commands are accepted every cycle
//   timeout_cycles       watchdog limit for a running test (0 = off)
//   test_done            per-test completion pulse
//   cfg_static_0/1       static configuration registers
//   execute_cfg          body of the last valid execute command
//   exec_start           one-hot start pulse to the selected test
//   exec_abort           abort pulse to all tests
//   fwd_valid/op/body    forwarded array/data command
//   rd_valid/rd_data     read response
//   busy                 a test is running
//   status               status word
//
// Optional feature (macro FW_CMD_DISPATCH_CMD_COUNT_EN):
//   When defined, a 16-bit counter of accepted commands addressed to this
//   instance is kept. NOOP returns {8'h00, count} on the read port, and
//   W_RST_FW clears the counter.
// ---------------------------------------------------------------------------
module fw_cmd_dispatch #(
    parameter logic [3:0] FIRMWARE_ID  = 4'h1,
    parameter int         NUM_TESTS    = 5,
    parameter int         TEST_NUM_LSB = 12,
    parameter int         TIMEOUT_W    = 20
) (
    input  logic                 fw_axi_clk,
    input  logic                 fw_rst,
    input  logic [31:0]          cmd_wdata,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [NUM_TESTS-1:0] test_done,
    output logic [23:0]          cfg_static_0,
    output logic [23:0]          cfg_static_1,
    output logic [23:0]          execute_cfg,
    output logic [NUM_TESTS-1:0] exec_start,
    output logic                 exec_abort,
    output logic                 fwd_valid,
    output logic [3:0]           fwd_op,
    output logic [23:0]          fwd_body,
    output logic                 rd_valid,
    output logic [23:0]          rd_data,
    output logic                 busy,
    output logic [31:0]          status
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [23:0]            r_cfg0, w_cfg0_nxt;
    logic [23:0]            r_cfg1, w_cfg1_nxt;
    logic [23:0]            r_exe, w_exe_nxt;
    logic [NUM_TESTS-1:0]   r_start, w_start_nxt;
    logic                   r_abort, w_abort_nxt;
    logic                   r_fwd_valid, w_fwd_valid_nxt;
    logic [3:0]             r_fwd_op, w_fwd_op_nxt;
    logic [23:0]            r_fwd_body, w_fwd_body_nxt;
    logic                   r_rd_valid, w_rd_valid_nxt;
    logic [23:0]            r_rd_data, w_rd_data_nxt;
    logic [31:0]            r_status, w_status_nxt;
    logic [3:0]             r_active, w_active_nxt;
    logic [TIMEOUT_W-1:0]   r_wdog, w_wdog_nxt;
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
    logic [15:0]            r_cnt, w_cnt_nxt;
`endif

    logic                   w_hit;
    logic [3:0]             w_op;
    logic [23:0]            w_body;
    logic [3:0]             w_tnum;
    logic                   w_t_ok;
    logic [NUM_TESTS-1:0]   w_start_vec;
    logic                   w_done_hit;
    logic                   w_to_hit;
    logic [TIMEOUT_W-1:0]   w_wdog_inc;

    assign cmd_ready    = 1'b1;
    assign cfg_static_0 = r_cfg0;
    assign cfg_static_1 = r_cfg1;
    assign execute_cfg  = r_exe;
    assign exec_start   = r_start;
    assign exec_abort   = r_abort;
    assign fwd_valid    = r_fwd_valid;
    assign fwd_op       = r_fwd_op;
    assign fwd_body     = r_fwd_body;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign busy         = (r_state == S_RUN);
    assign status       = r_status;

    assign w_hit  = cmd_valid && (cmd_wdata[31:28] == FIRMWARE_ID);
    assign w_op   = cmd_wdata[27:24];
    assign w_body = cmd_wdata[23:0];
    assign w_tnum = cmd_wdata[TEST_NUM_LSB +: 4];
    assign w_t_ok = (w_tnum != 4'd0) && ({28'd0, w_tnum} <= 32'(NUM_TESTS));

    // Watchdog value after the current RUN cycle; saturates at all-ones.
    // The timeout fires on the cycle this value reaches timeout_cycles, so
    // busy stays high for exactly timeout_cycles cycles.
    assign w_wdog_inc = (&r_wdog) ? r_wdog : r_wdog + 1'b1;

    always_comb begin
        w_start_vec = '0;
        w_done_hit  = 1'b0;
        for (int k = 0; k < NUM_TESTS; k++) begin
            w_start_vec[k] = (w_tnum == 4'(k + 1));
            if ((r_active == 4'(k)) && test_done[k])
                w_done_hit = 1'b1;
        end
        w_done_hit = w_done_hit && (r_state == S_RUN);
    end

    // Done on the active test wins over a simultaneous timeout.
    assign w_to_hit = (r_state == S_RUN) && !w_done_hit &&
                      (timeout_cycles != '0) && (w_wdog_inc == timeout_cycles);

    always_comb begin
        w_state_nxt     = r_state;
        w_cfg0_nxt      = r_cfg0;
        w_cfg1_nxt      = r_cfg1;
        w_exe_nxt       = r_exe;
        w_start_nxt     = '0;
        w_abort_nxt     = 1'b0;
        w_fwd_valid_nxt = 1'b0;
        w_fwd_op_nxt    = r_fwd_op;
        w_fwd_body_nxt  = r_fwd_body;
        w_rd_valid_nxt  = 1'b0;
        w_rd_data_nxt   = r_rd_data;
        w_status_nxt    = r_status;
        w_active_nxt    = r_active;
        w_wdog_nxt      = r_wdog;
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
        w_cnt_nxt       = r_cnt;
`endif

        // Test completion and watchdog are resolved first so that a command
        // in the same cycle (status clear, firmware reset) overrides them.
        if (r_state == S_RUN) begin
            w_wdog_nxt = w_wdog_inc;
            if (w_done_hit) begin
                w_status_nxt[5'd14 + {1'b0, r_active}] = 1'b1;
                w_state_nxt = S_IDLE;
            end else if (w_to_hit) begin
                w_status_nxt[30] = 1'b1;
                w_abort_nxt      = 1'b1;
                w_state_nxt      = S_IDLE;
            end
        end

        if (w_hit) begin
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
            w_cnt_nxt = r_cnt + 16'd1;
`endif
            case (w_op)
                4'h0: begin
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
                    // Reports the count of commands accepted before this NOOP.
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = {8'h00, r_cnt};
`endif
                end
                4'h1: begin
                    w_cfg0_nxt   = '0;
                    w_cfg1_nxt   = '0;
                    w_exe_nxt    = '0;
                    w_status_nxt = 32'h0000_0001;
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
                    w_cnt_nxt    = '0;
`endif
                    if (r_state == S_RUN) begin
                        w_abort_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                4'h2: begin
                    w_cfg0_nxt      = w_body;
                    w_status_nxt[1] = 1'b1;
                end
                4'h3: begin
                    w_rd_valid_nxt  = 1'b1;
                    w_rd_data_nxt   = r_cfg0;
                    w_status_nxt[2] = 1'b1;
                end
                4'h4: begin
                    w_cfg1_nxt      = w_body;
                    w_status_nxt[3] = 1'b1;
                end
                4'h5: begin
                    w_rd_valid_nxt  = 1'b1;
                    w_rd_data_nxt   = r_cfg1;
                    w_status_nxt[4] = 1'b1;
                end
                4'hE: begin
                    w_status_nxt = '0;
                end
                4'hF: begin
                    if (!w_t_ok || (r_state == S_RUN)) begin
                        w_status_nxt[31] = 1'b1;
                    end else begin
                        w_exe_nxt        = w_body;
                        w_start_nxt      = w_start_vec;
                        w_status_nxt[13] = 1'b1;
                        w_state_nxt      = S_RUN;
                        w_active_nxt     = w_tnum - 4'd1;
                        w_wdog_nxt       = '0;
                    end
                end
                default: begin
                    // 0x6..0xD: array/data ops, forwarded without handshake.
                    w_fwd_valid_nxt         = 1'b1;
                    w_fwd_op_nxt            = w_op;
                    w_fwd_body_nxt          = w_body;
                    w_status_nxt[w_op - 4'd1] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
        if (fw_rst) begin
            r_state     <= S_IDLE;
            r_cfg0      <= '0;
            r_cfg1      <= '0;
            r_exe       <= '0;
            r_start     <= '0;
            r_abort     <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_op    <= '0;
            r_fwd_body  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_status    <= '0;
            r_active    <= '0;
            r_wdog      <= '0;
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cfg0      <= w_cfg0_nxt;
            r_cfg1      <= w_cfg1_nxt;
            r_exe       <= w_exe_nxt;
            r_start     <= w_start_nxt;
            r_abort     <= w_abort_nxt;
            r_fwd_valid <= w_fwd_valid_nxt;
            r_fwd_op    <= w_fwd_op_nxt;
            r_fwd_body  <= w_fwd_body_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_status    <= w_status_nxt;
            r_active    <= w_active_nxt;
            r_wdog      <= w_wdog_nxt;
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fw_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fw_cmd_dispatch
//
// Self-checking bench for fw_cmd_dispatch with default parameters. A
// behavioural model tracks configuration, status and the running test;
// every cycle all DUT outputs are compared against it on the falling edge.
// Directed sequences cover the main scenarios, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_fw_cmd_dispatch;

    localparam int NT = 5;
    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cmd_wdata;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] timeout_cycles;
    logic [NT-1:0] test_done;
    logic [23:0]   cfg_static_0, cfg_static_1, execute_cfg;
    logic [NT-1:0] exec_start;
    logic          exec_abort, fwd_valid, rd_valid, busy;
    logic [3:0]    fwd_op;
    logic [23:0]   fwd_body, rd_data;
    logic [31:0]   status;

    fw_cmd_dispatch #(
        .FIRMWARE_ID  (4'h1),
        .NUM_TESTS    (NT),
        .TEST_NUM_LSB (12),
        .TIMEOUT_W    (TW)
    ) dut (
        .fw_axi_clk     (clk),
        .fw_rst         (rst),
        .cmd_wdata      (cmd_wdata),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .timeout_cycles (timeout_cycles),
        .test_done      (test_done),
        .cfg_static_0   (cfg_static_0),
        .cfg_static_1   (cfg_static_1),
        .execute_cfg    (execute_cfg),
        .exec_start     (exec_start),
        .exec_abort     (exec_abort),
        .fwd_valid      (fwd_valid),
        .fwd_op         (fwd_op),
        .fwd_body       (fwd_body),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy),
        .status         (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          m_run;
    int          m_active;
    int          m_wdog;      // completed RUN cycles of the current test
    logic [23:0] m_cfg0, m_cfg1, m_exe, m_rdd, m_fbody;
    logic [3:0]  m_fop;
    logic [31:0] m_status;
    logic [NT-1:0] m_start;
    bit          m_abort, m_rdv, m_fwdv;
    int          m_cnt;

    task automatic model_reset();
        m_run = 0; m_active = 0; m_wdog = 0;
        m_cfg0 = 0; m_cfg1 = 0; m_exe = 0; m_rdd = 0; m_fbody = 0; m_fop = 0;
        m_status = 0; m_start = 0; m_abort = 0; m_rdv = 0; m_fwdv = 0; m_cnt = 0;
    endtask

    // Applies one clock edge of the specification's rules to the model.
    task automatic model_clock();
        bit was_run;
        bit done_hit;
        int op;
        int t;
        logic [23:0] body;
        was_run = m_run;
        m_start = 0; m_abort = 0; m_rdv = 0; m_fwdv = 0;
        if (was_run) begin
            if (m_wdog < (1 << TW) - 1) m_wdog++;
            done_hit = test_done[m_active];
            if (done_hit) begin
                m_status[14 + m_active] = 1'b1;
                m_run = 0;
            end else if (timeout_cycles != 0 && m_wdog == int'(timeout_cycles)) begin
                m_status[30] = 1'b1;
                m_abort = 1;
                m_run = 0;
            end
        end
        if (cmd_valid && cmd_wdata[31:28] == 4'h1) begin
            op   = int'(cmd_wdata[27:24]);
            body = cmd_wdata[23:0];
            t    = int'(cmd_wdata[15:12]);
`ifdef FW_CMD_DISPATCH_CMD_COUNT_EN
            if (op == 0) begin
                m_rdv = 1;
                m_rdd = {8'h00, 16'(m_cnt)};
            end
            m_cnt = (m_cnt + 1) % 65536;
`endif
            if (op == 1) begin
                m_cfg0 = 0; m_cfg1 = 0; m_exe = 0;
                m_status = 32'h1;
                m_cnt = 0;
                if (was_run) begin
                    m_abort = 1;
                    m_run = 0;
                end
            end else if (op == 2 || op == 4) begin
                if (op == 2) m_cfg0 = body; else m_cfg1 = body;
                m_status[op - 1] = 1'b1;
            end else if (op == 3 || op == 5) begin
                m_rdv = 1;
                m_rdd = (op == 3) ? m_cfg0 : m_cfg1;
                m_status[op - 1] = 1'b1;
            end else if (op >= 6 && op <= 13) begin
                m_fwdv = 1;
                m_fop = 4'(op);
                m_fbody = body;
                m_status[op - 1] = 1'b1;
            end else if (op == 14) begin
                m_status = 0;
            end else if (op == 15) begin
                if (t == 0 || t > NT || was_run) begin
                    m_status[31] = 1'b1;
                end else begin
                    m_exe = body;
                    m_start[t - 1] = 1'b1;
                    m_status[13] = 1'b1;
                    m_run = 1;
                    m_active = t - 1;
                    m_wdog = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("cmd_ready",    cmd_ready,    32'd1);
        check("busy",         busy,         m_run);
        check("status",       status,       m_status);
        check("exec_start",   exec_start,   m_start);
        check("exec_abort",   exec_abort,   m_abort);
        check("rd_valid",     rd_valid,     m_rdv);
        check("rd_data",      rd_data,      m_rdd);
        check("fwd_valid",    fwd_valid,    m_fwdv);
        check("fwd_op",       fwd_op,       m_fop);
        check("fwd_body",     fwd_body,     m_fbody);
        check("cfg_static_0", cfg_static_0, m_cfg0);
        check("cfg_static_1", cfg_static_1, m_cfg1);
        check("execute_cfg",  execute_cfg,  m_exe);
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input logic v, input logic [31:0] w, input logic [NT-1:0] d);
        cmd_valid = v;
        cmd_wdata = w;
        test_done = d;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
        cmd_valid = 1'b0;
        test_done = '0;
    endtask

    initial begin
        #2ms;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        int lat;
        logic [3:0]  r_id;
        logic [3:0]  r_op;
        logic [23:0] r_body;

        rst = 1'b1; cmd_valid = 1'b0; cmd_wdata = '0; test_done = '0; timeout_cycles = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        check("reset_status", status, 32'h0);
        rst = 1'b0;

        // Write and read back static config 0.
        cyc(1'b1, 32'h12ABCDEF, '0);
        check("cfg0_written", cfg_static_0, 24'hABCDEF);
        cyc(1'b1, 32'h13000000, '0);
        check("rd_cfg0_data", rd_data, 24'hABCDEF);
        check("rd_cfg0_valid", rd_valid, 1'b1);
        check("status_0x6", status, 32'h6);

        // Foreign device id is ignored.
        cyc(1'b1, 32'h22123456, '0);
        check("foreign_cfg0", cfg_static_0, 24'hABCDEF);
        check("foreign_status", status, 32'h6);

        // NOOP
        cyc(1'b1, 32'h10000000, '0);
`ifndef FW_CMD_DISPATCH_CMD_COUNT_EN
        check("noop_no_rd", rd_valid, 1'b0);
`endif

        // Execute test 3, done after 10 cycles.
        cyc(1'b1, 32'h1F003000, '0);
        check("start_t3", exec_start, 5'b00100);
        busy_cnt = busy;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, '0, '0);
            busy_cnt += busy;
            check("start_single", exec_start, 5'b00000);
        end
        cyc(1'b0, '0, 5'b00100);
        check("done_busy_low", busy, 1'b0);
        check("busy_len", busy_cnt, 10);
        check("status_b13", status[13], 1'b1);
        check("status_b16", status[16], 1'b1);

        // Out-of-range test number.
        cyc(1'b1, 32'h1F006ABC, '0);
        check("bad_t_err", status[31], 1'b1);
        check("bad_t_nostart", exec_start, 5'b00000);
        check("bad_t_cfg", execute_cfg, 24'h003000);

        // Execute while running.
        cyc(1'b1, 32'h1E000000, '0);
        cyc(1'b1, 32'h1F0F1001, '0);
        check("start_t1", exec_start, 5'b00001);
        cyc(1'b1, 32'h1F002000, '0);
        check("run_exec_err", status[31], 1'b1);
        check("run_exec_nostart", exec_start, 5'b00000);
        check("run_exec_cfg", execute_cfg, 24'h0F1001);
        check("run_exec_busy", busy, 1'b1);
        cyc(1'b0, '0, 5'b00001);

        // Watchdog timeout after 8 RUN cycles.
        timeout_cycles = 20'd8;
        cyc(1'b1, 32'h1E000000, '0);
        cyc(1'b1, 32'h1F001000, '0);
        lat = 0;
        do begin
            cyc(1'b0, '0, '0);
            lat++;
        end while (!exec_abort && lat < 50);
        check("timeout_latency", lat, 8);
        check("timeout_b30", status[30], 1'b1);
        check("timeout_busy", busy, 1'b0);

        // Done and timeout in the same cycle: done wins.
        timeout_cycles = 20'd4;
        cyc(1'b1, 32'h1E000000, '0);
        cyc(1'b1, 32'h1F001000, '0);
        repeat (3) cyc(1'b0, '0, '0);
        cyc(1'b0, '0, 5'b00001);
        check("dt_b30", status[30], 1'b0);
        check("dt_b14", status[14], 1'b1);
        check("dt_abort", exec_abort, 1'b0);
        timeout_cycles = '0;

        // Status clear coincident with done.
        cyc(1'b1, 32'h1F002000, '0);
        cyc(1'b0, '0, '0);
        cyc(1'b1, 32'h1E000000, 5'b00010);
        check("clr_done_status", status, 32'h0);
        check("clr_done_busy", busy, 1'b0);

        // Firmware reset command while running.
        cyc(1'b1, 32'h14123456, '0);
        cyc(1'b1, 32'h1F005000, '0);
        cyc(1'b1, 32'h11000000, '0);
        check("rstcmd_abort", exec_abort, 1'b1);
        check("rstcmd_status", status, 32'h1);
        check("rstcmd_cfg1", cfg_static_1, 24'h0);

        // Hardware reset while running: no abort pulse.
        cyc(1'b1, 32'h12777777, '0);
        cyc(1'b1, 32'h1F004000, '0);
        rst = 1'b1;
        #2;
        model_reset();
        check("hwrst_abort", exec_abort, 1'b0);
        check("hwrst_busy", busy, 1'b0);
        check("hwrst_cfg0", cfg_static_0, 24'h0);
        check("hwrst_status", status, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                timeout_cycles = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 30));
            r_id   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
            r_op   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            r_body = 24'($urandom);
            r_body[15:12] = 4'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), {r_id, r_op, r_body},
                ($urandom_range(0, 5) == 0) ? NT'($urandom) : '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
